// File: rtl/fsm_arb_pkg.sv
// Shared types and constants for the fsm_2 input arbiter.
package fsm_arb_pkg;

    // Arbiter control states; LOCKED is only entered when FSM_ALARM_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        LOCKED = 2'd3
    } arb_state_e;

    // Command word as presented on the fsm_2 inputs, A in the MSB.
    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } fsm_cmd_t;

    // fsm_2 out[1:0] encodings; 01 is never produced by a healthy fsm_2.
    localparam logic [1:0] FSM_S00     = 2'b00;
    localparam logic [1:0] FSM_S10     = 2'b10;
    localparam logic [1:0] FSM_S11     = 2'b11;
    localparam logic [1:0] FSM_ILLEGAL = 2'b01;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      index
);

    logic        found;
    logic [31:0] j;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            j = (32'(pointer) + i) % NUM_REQ;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = PW'(j);
            end
        end
    end

endmodule

// File: rtl/fsm_input_arbiter.sv
// Shares the {A,B,C,D} input port of fsm_2 between NUM_REQ requesters.
// A round-robin winner's command is driven for HOLD_CYCLES clocks, then the
// fsm_2 state is sampled and returned with a one-cycle done pulse.
// Optional macro FSM_ALARM_EN: illegal fsm_2 state detection, abort and lock-up.
module fsm_input_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] cmd,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [1:0]           rsp_state,
    output logic                 rsp_err,
    output logic                 fsm_A,
    output logic                 fsm_B,
    output logic                 fsm_C,
    output logic                 fsm_D,
    input  logic [1:0]           fsm_out,
    output logic                 alarm
);

    localparam int unsigned PW        = $clog2(NUM_REQ);
    localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [3:0]         hold_cnt_q;
    logic [PW-1:0]      rr_ptr_q;
    logic [PW-1:0]      win_idx_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [1:0]         rsp_state_q;
    logic               rsp_err_q;
    logic               alarm_q;
    fsm_cmd_t           drv_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      arb_idx;
    fsm_cmd_t           cmd_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (req),
        .pointer (rr_ptr_q),
        .grant   (arb_gnt),
        .index   (arb_idx)
    );

    assign cmd_sel = fsm_cmd_t'(cmd[{arb_idx, 2'b00} +: 4]);

`ifdef FSM_ALARM_EN
    logic illegal;
    assign illegal = (fsm_out == FSM_ILLEGAL);
`endif

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            rr_ptr_q    <= '0;
            win_idx_q   <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            rsp_state_q <= FSM_S00;
            rsp_err_q   <= 1'b0;
            alarm_q     <= 1'b0;
            drv_q       <= '0;
        end else begin
`ifdef FSM_ALARM_EN
            if (illegal) begin
                alarm_q <= 1'b1;
            end
`endif
            case (state_q)
                IDLE: begin
`ifdef FSM_ALARM_EN
                    if (illegal) begin
                        state_q <= LOCKED;
                    end else
`endif
                    if (|req) begin
                        gnt_q      <= arb_gnt;
                        win_idx_q  <= arb_idx;
                        drv_q      <= cmd_sel;
                        hold_cnt_q <= '0;
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
`ifdef FSM_ALARM_EN
                    if (illegal) begin
                        // Abort: report the bad state to the winner, then lock.
                        drv_q       <= '0;
                        done_q      <= gnt_q;
                        rsp_err_q   <= 1'b1;
                        rsp_state_q <= FSM_ILLEGAL;
                        state_q     <= SAMPLE;
                    end else
`endif
                    if (hold_cnt_q == HOLD_LAST) begin
                        rsp_state_q <= fsm_out;
                        done_q      <= gnt_q;
                        drv_q       <= '0;
                        state_q     <= SAMPLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 4'd1;
                    end
                end
                SAMPLE: begin
                    gnt_q     <= '0;
                    done_q    <= '0;
                    rsp_err_q <= 1'b0;
                    rr_ptr_q  <= (win_idx_q == PTR_LAST) ? '0 : win_idx_q + 1'b1;
`ifdef FSM_ALARM_EN
                    state_q   <= (illegal || alarm_q) ? LOCKED : IDLE;
`else
                    state_q   <= IDLE;
`endif
                end
                LOCKED: begin
                    gnt_q  <= '0;
                    done_q <= '0;
                    drv_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rsp_state = rsp_state_q;
    assign rsp_err   = rsp_err_q;
    assign alarm     = alarm_q;
    assign fsm_A     = drv_q.a;
    assign fsm_B     = drv_q.b;
    assign fsm_C     = drv_q.c;
    assign fsm_D     = drv_q.d;

endmodule

// File: tb/tb_fsm_input_arbiter.sv
// Directed self-checking bench for fsm_input_arbiter (NUM_REQ=4, HOLD_CYCLES=2).
// Follows FSM_ALARM_EN to pick the matching illegal-state scenario.
module tb_fsm_input_arbiter;

    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [4*N-1:0] cmd;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [1:0]    rsp_state;
    logic          rsp_err;
    logic          fsm_A, fsm_B, fsm_C, fsm_D;
    logic [1:0]    fsm_out;
    logic          alarm;

    int n_checks = 0;
    int n_fail   = 0;

    fsm_input_arbiter #(
        .NUM_REQ     (N),
        .HOLD_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cmd       (cmd),
        .gnt       (gnt),
        .done      (done),
        .rsp_state (rsp_state),
        .rsp_err   (rsp_err),
        .fsm_A     (fsm_A),
        .fsm_B     (fsm_B),
        .fsm_C     (fsm_C),
        .fsm_D     (fsm_D),
        .fsm_out   (fsm_out),
        .alarm     (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] drv();
        return {fsm_A, fsm_B, fsm_C, fsm_D};
    endfunction

    // One full transaction to requester idx, with optional mid-DRIVE disturbance.
    task automatic run_txn(input string tag, input int idx, input logic [3:0] exp_cmd,
                           input logic [1:0] st, input logic [N-1:0] req_mid,
                           input logic [4*N-1:0] cmd_mid, input logic [N-1:0] req_done);
        logic [N-1:0] oh;
        oh = N'(1) << idx;
        tick();
        chk({tag, ".gnt0"}, 32'(gnt), 32'(oh));
        chk({tag, ".drv0"}, 32'(drv()), 32'(exp_cmd));
        chk({tag, ".done0"}, 32'(done), 32'(0));
        fsm_out = st;
        req     = req_mid;
        cmd     = cmd_mid;
        tick();
        chk({tag, ".gnt1"}, 32'(gnt), 32'(oh));
        chk({tag, ".drv1"}, 32'(drv()), 32'(exp_cmd));
        chk({tag, ".done1"}, 32'(done), 32'(0));
        tick();
        chk({tag, ".done"}, 32'(done), 32'(oh));
        chk({tag, ".gnt2"}, 32'(gnt), 32'(oh));
        chk({tag, ".rsp"}, 32'(rsp_state), 32'(st));
        chk({tag, ".err"}, 32'(rsp_err), 32'(0));
        chk({tag, ".drv2"}, 32'(drv()), 32'(0));
        req     = req_done;
        fsm_out = 2'b00;
        tick();
        chk({tag, ".idle_gnt"}, 32'(gnt), 32'(0));
        chk({tag, ".idle_done"}, 32'(done), 32'(0));
    endtask

    logic [1:0] rot_st [5];

    initial begin
        rst     = 1'b0;
        req     = '0;
        cmd     = '0;
        fsm_out = 2'b00;
        rot_st  = '{2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
        #12;
        chk("rst.gnt", 32'(gnt), 32'(0));
        chk("rst.done", 32'(done), 32'(0));
        chk("rst.rsp", 32'(rsp_state), 32'(0));
        chk("rst.err", 32'(rsp_err), 32'(0));
        chk("rst.drv", 32'(drv()), 32'(0));
        chk("rst.alarm", 32'(alarm), 32'(0));
        tick();
        rst = 1'b1;

        // No request: stays idle.
        tick();
        tick();
        chk("noreq.gnt", 32'(gnt), 32'(0));
        chk("noreq.drv", 32'(drv()), 32'(0));

        // Single request, command C, fsm moves 00 -> 10.
        req = 4'b0001;
        cmd = 16'h0002;
        run_txn("t1", 0, 4'b0010, 2'b10, 4'b0001, 16'h0002, 4'b0000);

        // Reset mid-DRIVE: pointer is 1, requester 1 wins first.
        req = 4'b0010;
        cmd = 16'h0040;
        tick();
        chk("rstm.gnt", 32'(gnt), 32'(4'b0010));
        chk("rstm.drv", 32'(drv()), 32'(4'b0100));
        rst = 1'b0;
        #1;
        chk("rstm.async_gnt", 32'(gnt), 32'(0));
        chk("rstm.async_drv", 32'(drv()), 32'(0));
        tick();
        chk("rstm.done", 32'(done), 32'(0));
        chk("rstm.rsp", 32'(rsp_state), 32'(0));
        rst = 1'b1;

        // All requesting: strict rotation from pointer 0, including wrap.
        req = 4'b1111;
        cmd = 16'h8142;
        run_txn("rot0", 0, 4'b0010, rot_st[0], 4'b1111, 16'h8142, 4'b1111);
        run_txn("rot1", 1, 4'b0100, rot_st[1], 4'b1111, 16'h8142, 4'b1111);
        run_txn("rot2", 2, 4'b0001, rot_st[2], 4'b1111, 16'h8142, 4'b1111);
        run_txn("rot3", 3, 4'b1000, rot_st[3], 4'b1111, 16'h8142, 4'b1111);
        run_txn("rot4", 0, 4'b0010, rot_st[4], 4'b1111, 16'h8142, 4'b0000);

        // Req drop and cmd change during DRIVE are ignored.
        req = 4'b0010;
        cmd = 16'h0040;
        run_txn("drop", 1, 4'b0100, 2'b11, 4'b0000, 16'hFFFF, 4'b0000);

`ifdef FSM_ALARM_EN
        // Illegal state during DRIVE: abort, report, lock.
        req = 4'b0001;
        cmd = 16'h0002;
        tick();
        chk("al.gnt", 32'(gnt), 32'(4'b0001));
        fsm_out = 2'b01;
        tick();
        chk("al.done", 32'(done), 32'(4'b0001));
        chk("al.err", 32'(rsp_err), 32'(1));
        chk("al.rsp", 32'(rsp_state), 32'(2'b01));
        chk("al.alarm", 32'(alarm), 32'(1));
        chk("al.drv", 32'(drv()), 32'(0));
        fsm_out = 2'b00;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("al.lock_gnt", 32'(gnt), 32'(0));
            chk("al.lock_alarm", 32'(alarm), 32'(1));
        end
        rst = 1'b0;
        #1;
        chk("al.rst_alarm", 32'(alarm), 32'(0));
        rst = 1'b1;
`else
        // 01 sampled like any other state; pointer 2 wraps to requester 0.
        req = 4'b0001;
        cmd = 16'h0002;
        run_txn("ill", 0, 4'b0010, 2'b01, 4'b0001, 16'h0002, 4'b0000);
        chk("ill.alarm", 32'(alarm), 32'(0));
        req = 4'b0011;
        cmd = 16'h0042;
        run_txn("ill.next", 1, 4'b0100, 2'b10, 4'b0011, 16'h0042, 4'b0000);
        chk("ill.alarm2", 32'(alarm), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
